// File: rtl/barrier_client_unit.sv
// barrier_client_unit: initiator side of the barrier account/release protocol.
// Captures per-thread barrier requests, stalls the requesting threads, sends one
// account message per request to the barrier's master tile and un-stalls every
// thread waiting on a barrier when its release message arrives.
module barrier_client_unit #(
  parameter int TILE_ID      = 0,
  parameter int TILE_COUNT   = 16,
  parameter int THREAD_NUMB  = 8,
  parameter int BARRIER_ID_W = 16,
  parameter int CNT_W        = 16,
  localparam int TW = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1,
  localparam int DW = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_barrier_valid,
  input  logic [TW-1:0]           core_barrier_thread,
  input  logic [BARRIER_ID_W-1:0] core_barrier_id,
  input  logic [CNT_W-1:0]        core_barrier_cnt,
  output logic [THREAD_NUMB-1:0]  bc_thread_stall,
  output logic                    bc_error,
  input  logic                    ni_account_available,
  output logic                    bc_account_valid,
  output logic [BARRIER_ID_W-1:0] bc_account_id,
  output logic [CNT_W-1:0]        bc_account_cnt,
  output logic [DW-1:0]           bc_account_tile_src,
  output logic [DW-1:0]           bc_account_dest,
  input  logic                    ni_release_valid,
  input  logic [BARRIER_ID_W-1:0] ni_release_id,
  output logic                    bc_release_consumed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } thread_state_e;

  thread_state_e           state_q [THREAD_NUMB];
  thread_state_e           state_d [THREAD_NUMB];
  logic [BARRIER_ID_W-1:0] id_q    [THREAD_NUMB];
  logic [CNT_W-1:0]        cnt_q   [THREAD_NUMB];
  logic [TW-1:0]           rr_ptr_q;
  logic [TW-1:0]           grant_idx;
  logic [TW-1:0]           cand;
  logic                    grant_found;
  logic                    transfer;
  logic                    req_accept;
  logic                    req_busy;
  logic [THREAD_NUMB-1:0]  stall_q;
  logic                    error_q;

  // Round-robin search for the first SEND thread starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < THREAD_NUMB; i++) begin
      cand = TW'((int'(rr_ptr_q) + i) % THREAD_NUMB);
      if (!grant_found && state_q[cand] == SEND) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // An account goes out whenever the NI can take it; held low while in reset.
  assign transfer   = reset && ni_account_available && grant_found;
  assign req_accept = core_barrier_valid && state_q[core_barrier_thread] == IDLE;
  assign req_busy   = core_barrier_valid && state_q[core_barrier_thread] != IDLE;

  // Per-thread next state; matching uses only the state at the start of the cycle.
  always_comb begin
    for (int i = 0; i < THREAD_NUMB; i++) begin
      state_d[i] = state_q[i];
    end
    for (int i = 0; i < THREAD_NUMB; i++) begin
      case (state_q[i])
        IDLE: if (core_barrier_valid && core_barrier_thread == TW'(i)) state_d[i] = SEND;
        SEND: if (transfer && grant_idx == TW'(i)) state_d[i] = WAIT;
        WAIT: if (ni_release_valid && id_q[i] == ni_release_id) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // State, round-robin pointer, registered stall vector and error pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < THREAD_NUMB; i++) begin
        state_q[i] <= IDLE;
      end
      rr_ptr_q <= '0;
      stall_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      for (int i = 0; i < THREAD_NUMB; i++) begin
        state_q[i] <= state_d[i];
        stall_q[i] <= (state_d[i] != IDLE);
      end
      if (transfer) begin
        rr_ptr_q <= TW'((int'(grant_idx) + 1) % THREAD_NUMB);
      end
      error_q <= req_busy;
    end
  end

  // Barrier id/count storage; only meaningful while the thread is not IDLE, so no reset.
  always_ff @(posedge clk) begin
    if (req_accept) begin
      id_q[core_barrier_thread]  <= core_barrier_id;
      cnt_q[core_barrier_thread] <= core_barrier_cnt;
    end
  end

  assign bc_thread_stall     = stall_q;
  assign bc_error            = error_q;
  assign bc_account_valid    = transfer;
  assign bc_account_id       = id_q[grant_idx];
  assign bc_account_cnt      = cnt_q[grant_idx];
  assign bc_account_dest     = id_q[grant_idx][DW-1:0];
  assign bc_account_tile_src = DW'(TILE_ID);
  assign bc_release_consumed = ni_release_valid;

endmodule

// File: tb/tb_barrier_client_unit.sv
// tb_barrier_client_unit: directed self-checking bench for barrier_client_unit.
module tb_barrier_client_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_barrier_valid;
  logic [2:0]  core_barrier_thread;
  logic [15:0] core_barrier_id;
  logic [15:0] core_barrier_cnt;
  logic [7:0]  bc_thread_stall;
  logic        bc_error;
  logic        ni_account_available;
  logic        bc_account_valid;
  logic [15:0] bc_account_id;
  logic [15:0] bc_account_cnt;
  logic [3:0]  bc_account_tile_src;
  logic [3:0]  bc_account_dest;
  logic        ni_release_valid;
  logic [15:0] ni_release_id;
  logic        bc_release_consumed;

  int checkCount = 0;
  int errorCount = 0;

  barrier_client_unit #(
    .TILE_ID(5), .TILE_COUNT(16), .THREAD_NUMB(8), .BARRIER_ID_W(16), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .core_barrier_valid(core_barrier_valid), .core_barrier_thread(core_barrier_thread),
    .core_barrier_id(core_barrier_id), .core_barrier_cnt(core_barrier_cnt),
    .bc_thread_stall(bc_thread_stall), .bc_error(bc_error),
    .ni_account_available(ni_account_available), .bc_account_valid(bc_account_valid),
    .bc_account_id(bc_account_id), .bc_account_cnt(bc_account_cnt),
    .bc_account_tile_src(bc_account_tile_src), .bc_account_dest(bc_account_dest),
    .ni_release_valid(ni_release_valid), .ni_release_id(ni_release_id),
    .bc_release_consumed(bc_release_consumed)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] t, input logic [15:0] id, input logic [15:0] cnt);
    core_barrier_valid  = v;
    core_barrier_thread = t;
    core_barrier_id     = id;
    core_barrier_cnt    = cnt;
  endtask

  task automatic applyRelease(input logic v, input logic [15:0] id);
    ni_release_valid = v;
    ni_release_id    = id;
  endtask

  task automatic checkAccount(input string tag, input logic expValid, input logic [15:0] expId, input logic [15:0] expCnt);
    checkOutput({tag, " valid"}, 32'(bc_account_valid), 32'(expValid));
    if (expValid) begin
      checkOutput({tag, " id"}, 32'(bc_account_id), 32'(expId));
      checkOutput({tag, " cnt"}, 32'(bc_account_cnt), 32'(expCnt));
      checkOutput({tag, " dest"}, 32'(bc_account_dest), {28'd0, expId[3:0]});
      checkOutput({tag, " src"}, 32'(bc_account_tile_src), 32'd5);
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0);
    applyRelease(1'b1, 16'h0003);
    #1;
    checkOutput("reset consumed", 32'(bc_release_consumed), 32'd1);
    cycle();
    cycle();
    checkOutput("reset stall", 32'(bc_thread_stall), 32'h0);
    checkOutput("reset error", 32'(bc_error), 32'd0);
    reset = 1'b1;
    applyRelease(1'b0, 16'h0);
    #1;
  endtask

  logic [15:0] relIds [5] = '{16'h0100, 16'h0201, 16'h0505, 16'h0404, 16'h0707};

  initial begin
    reset = 1'b0;
    ni_account_available = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0);
    applyRelease(1'b0, 16'h0);
    doReset();

    // Single thread
    applyStimulus(1'b1, 3'd2, 16'h0013, 16'd3);
    cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0);
    #1;
    checkAccount("single acct", 1'b1, 16'h0013, 16'd3);
    checkOutput("single stall", 32'(bc_thread_stall), 32'h04);
    cycle();
    #1;
    checkAccount("single after", 1'b0, 16'h0, 16'h0);
    checkOutput("single wait stall", 32'(bc_thread_stall), 32'h04);
    applyRelease(1'b1, 16'h0013);
    #1;
    checkOutput("single consumed", 32'(bc_release_consumed), 32'd1);
    cycle();
    applyRelease(1'b0, 16'h0);
    #1;
    checkOutput("single released", 32'(bc_thread_stall), 32'h0);

    // Back-pressure, starting from rr_ptr = 0
    doReset();
    ni_account_available = 1'b0;
    applyStimulus(1'b1, 3'd0, 16'h0100, 16'd1); cycle();
    applyStimulus(1'b1, 3'd1, 16'h0201, 16'd2); cycle();
    applyStimulus(1'b1, 3'd5, 16'h0505, 16'd5); cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0);
    #1;
    checkOutput("bp stall", 32'(bc_thread_stall), 32'h23);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp hold valid", 32'(bc_account_valid), 32'd0);
      cycle();
    end
    ni_account_available = 1'b1;
    #1;
    checkAccount("bp acct0", 1'b1, 16'h0100, 16'd1);
    cycle(); #1;
    checkAccount("bp acct1", 1'b1, 16'h0201, 16'd2);
    cycle(); #1;
    checkAccount("bp acct5", 1'b1, 16'h0505, 16'd5);
    cycle(); #1;
    checkAccount("bp done", 1'b0, 16'h0, 16'h0);
    // rr_ptr is now 6, so thread 7 wins over thread 4
    ni_account_available = 1'b0;
    applyStimulus(1'b1, 3'd4, 16'h0404, 16'd4); cycle();
    applyStimulus(1'b1, 3'd7, 16'h0707, 16'd7); cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0);
    ni_account_available = 1'b1;
    #1;
    checkAccount("rr acct7", 1'b1, 16'h0707, 16'd7);
    cycle(); #1;
    checkAccount("rr acct4", 1'b1, 16'h0404, 16'd4);
    cycle(); #1;
    checkAccount("rr done", 1'b0, 16'h0, 16'h0);
    checkOutput("rr stall", 32'(bc_thread_stall), 32'hB3);
    for (int i = 0; i < 5; i++) begin
      applyRelease(1'b1, relIds[i]);
      cycle();
    end
    applyRelease(1'b0, 16'h0);
    #1;
    checkOutput("bp all released", 32'(bc_thread_stall), 32'h0);

    // Multi-thread release
    applyStimulus(1'b1, 3'd1, 16'd7, 16'd2); cycle();
    applyStimulus(1'b1, 3'd3, 16'd7, 16'd2); #1;
    checkAccount("multi acct t1", 1'b1, 16'd7, 16'd2);
    cycle();
    applyStimulus(1'b1, 3'd4, 16'd9, 16'd0); #1;
    checkAccount("multi acct t3", 1'b1, 16'd7, 16'd2);
    cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0); #1;
    checkAccount("multi acct t4", 1'b1, 16'd9, 16'd0);
    cycle(); #1;
    checkAccount("multi idle", 1'b0, 16'h0, 16'h0);
    checkOutput("multi stall before", 32'(bc_thread_stall), 32'h1A);
    applyRelease(1'b1, 16'd7);
    cycle();
    applyRelease(1'b0, 16'h0); #1;
    checkOutput("multi stall after", 32'(bc_thread_stall), 32'h10);
    applyRelease(1'b1, 16'h0055); #1;
    checkOutput("nomatch consumed", 32'(bc_release_consumed), 32'd1);
    cycle();
    applyRelease(1'b0, 16'h0); #1;
    checkOutput("nomatch stall", 32'(bc_thread_stall), 32'h10);
    applyRelease(1'b1, 16'd9);
    cycle();
    applyRelease(1'b0, 16'h0); #1;
    checkOutput("multi stall final", 32'(bc_thread_stall), 32'h0);

    // Error / duplicate request
    applyStimulus(1'b1, 3'd0, 16'h00AA, 16'd2); cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0); #1;
    checkAccount("dup first acct", 1'b1, 16'h00AA, 16'd2);
    cycle(); #1;
    checkAccount("dup waiting", 1'b0, 16'h0, 16'h0);
    checkOutput("dup no error", 32'(bc_error), 32'd0);
    applyStimulus(1'b1, 3'd0, 16'h00BB, 16'd5); cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0); #1;
    checkOutput("dup error pulse", 32'(bc_error), 32'd1);
    checkAccount("dup no acct", 1'b0, 16'h0, 16'h0);
    checkOutput("dup stall", 32'(bc_thread_stall), 32'h01);
    cycle(); #1;
    checkOutput("dup error clear", 32'(bc_error), 32'd0);
    applyRelease(1'b1, 16'h00BB); cycle();
    applyRelease(1'b0, 16'h0); #1;
    checkOutput("dup id kept", 32'(bc_thread_stall), 32'h01);
    applyRelease(1'b1, 16'h00AA); cycle();
    applyRelease(1'b0, 16'h0); #1;
    checkOutput("dup released", 32'(bc_thread_stall), 32'h0);

    // Grant and matching release in the same cycle
    ni_account_available = 1'b0;
    applyStimulus(1'b1, 3'd6, 16'h0066, 16'd1); cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0);
    ni_account_available = 1'b1;
    applyRelease(1'b1, 16'h0066); #1;
    checkAccount("simul acct", 1'b1, 16'h0066, 16'd1);
    checkOutput("simul consumed", 32'(bc_release_consumed), 32'd1);
    cycle();
    applyRelease(1'b0, 16'h0); #1;
    checkOutput("simul still stalled", 32'(bc_thread_stall), 32'h40);
    checkAccount("simul no acct", 1'b0, 16'h0, 16'h0);
    applyRelease(1'b1, 16'h0066); cycle();
    applyRelease(1'b0, 16'h0);
    applyStimulus(1'b1, 3'd6, 16'h0067, 16'd3); #1;
    checkOutput("rerequest released", 32'(bc_thread_stall), 32'h0);
    cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0); #1;
    checkOutput("rerequest stall", 32'(bc_thread_stall), 32'h40);
    checkAccount("rerequest acct", 1'b1, 16'h0067, 16'd3);
    cycle();
    applyRelease(1'b1, 16'h0067); cycle();
    applyRelease(1'b0, 16'h0); #1;
    checkOutput("rerequest done", 32'(bc_thread_stall), 32'h0);

    // Reset mid-operation with 2 WAIT and 3 SEND threads
    applyStimulus(1'b1, 3'd0, 16'h0030, 16'd1); cycle();
    applyStimulus(1'b1, 3'd1, 16'h0031, 16'd1); cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0); cycle();
    ni_account_available = 1'b0;
    applyStimulus(1'b1, 3'd2, 16'h0032, 16'd1); cycle();
    applyStimulus(1'b1, 3'd3, 16'h0033, 16'd1); cycle();
    applyStimulus(1'b1, 3'd5, 16'h0035, 16'd1); cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0); #1;
    checkOutput("midreset stall before", 32'(bc_thread_stall), 32'h2F);
    reset = 1'b0;
    ni_account_available = 1'b1;
    #1;
    checkOutput("midreset valid in reset", 32'(bc_account_valid), 32'd0);
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    checkOutput("midreset stall after", 32'(bc_thread_stall), 32'h0);
    checkOutput("midreset error", 32'(bc_error), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("midreset no acct", 32'(bc_account_valid), 32'd0);
      cycle();
    end
    ni_account_available = 1'b0;
    applyStimulus(1'b1, 3'd3, 16'h0043, 16'd2); cycle();
    applyStimulus(1'b1, 3'd0, 16'h0040, 16'd2); cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 16'h0);
    ni_account_available = 1'b1;
    #1;
    checkAccount("midreset rr t0", 1'b1, 16'h0040, 16'd2);
    cycle(); #1;
    checkAccount("midreset rr t3", 1'b1, 16'h0043, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
